// File: rtl/register_file_multiport.sv
// Multi-port register file: one byte-masked write port, NUM_READ registered write-first read ports,
// and a clear engine that zeroes the array after Reset or on a Clear request.
module register_file_multiport #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           WriteEnable,
  input  logic [ADDR_WIDTH-1:0]          WriteAddress,
  input  logic [DATA_WIDTH-1:0]          WriteData,
  input  logic [DATA_WIDTH/8-1:0]        ByteEnable,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ReadAddress,
  output logic [NUM_READ*DATA_WIDTH-1:0] ReadData,
  input  logic                           Clear,
  output logic                           Busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  state_t                         r_state;
  logic [ADDR_WIDTH-1:0]          r_clr_ptr;
  logic                           r_busy;
  logic [DATA_WIDTH-1:0]          r_mem [DEPTH];
  logic [NUM_READ*DATA_WIDTH-1:0] r_rd_p1;

  logic                           w_wr_en;
  logic                           w_clr_en;
  logic [DATA_WIDTH-1:0]          w_merge;
  logic [NUM_READ*DATA_WIDTH-1:0] w_rd_p0;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // Writes to word 0 are dropped when it is hardwired to zero, so the bypass never sees them either.
  assign w_wr_en  = (r_state == S_IDLE) && !Reset && WriteEnable &&
                    !((ZERO_REG != 0) && (WriteAddress == '0));
  assign w_clr_en = (r_state == S_CLEAR) && !Reset;
  assign w_merge  = merge_bytes(r_mem[WriteAddress], WriteData, ByteEnable);

  always_ff @(posedge Clock) begin
    if (w_clr_en) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr_en) begin
      r_mem[WriteAddress] <= w_merge;
    end
  end

  // Stage p0: read mux with write-first bypass
  always_comb begin
    w_rd_p0 = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      if ((ZERO_REG != 0) && (ReadAddress[k*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
        w_rd_p0[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if (w_wr_en && (ReadAddress[k*ADDR_WIDTH +: ADDR_WIDTH] == WriteAddress)) begin
        w_rd_p0[k*DATA_WIDTH +: DATA_WIDTH] = w_merge;
      end else begin
        w_rd_p0[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[ReadAddress[k*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

  // Stage p1: control FSM and registered read data
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
      r_busy    <= 1'b1;
      r_rd_p1   <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_rd_p1   <= '0;
          r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
          if (r_clr_ptr == '1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          r_rd_p1 <= w_rd_p0;
          if (Clear) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign ReadData = r_rd_p1;
  assign Busy     = r_busy;

endmodule
